// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Iterative 32-bit multiply/divide unit for the MIPS32 execute
//            stage. Computes MULT, MULTU, DIV and DIVU over 32 iteration
//            cycles into the architectural HI/LO registers, with a direct
//            write port for MTHI/MTLO.
// Ports    : clk      - clock, all state updates on the rising edge
//            reset    - synchronous, active-high reset
//            start    - launch op on a/b (sampled only while idle)
//            op[1:0]  - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//            a[31:0]  - rs operand (multiplicand / dividend)
//            b[31:0]  - rt operand (multiplier / divisor)
//            wr_hi    - MTHI: write wr_data into HI (idle only)
//            wr_lo    - MTLO: write wr_data into LO (idle only)
//            wr_data  - data for MTHI/MTLO
//            busy     - operation in progress, core stalls on it
//            done     - one-cycle pulse when an operation updates HI/LO
//            hi, lo   - HI/LO registers
// Config   : MDU_DIV_EN - when defined the divide datapath is built; when
//            undefined, start with op[1]=1 is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    // Low half holds the multiplier (shifted out LSB first) or the dividend
    // (shifted out MSB first, replaced by quotient bits). High half is the
    // multiply partial-product accumulator.
    logic [63:0] r_prod;
    logic [31:0] r_opnd;    // |multiplicand| or |divisor|
    logic        r_sa;      // sign of a (signed ops only)
    logic        r_neg;     // sign(a) != sign(b) (signed ops only)

    logic        w_signed;
    logic        w_accept;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_sum;
    logic [63:0] w_prod_fix;

    assign w_signed = ~op[0];
    // 0x8000_0000 negates to itself, which is its correct unsigned magnitude.
    assign w_abs_a  = (w_signed && a[31]) ? (32'd0 - a) : a;
    assign w_abs_b  = (w_signed && b[31]) ? (32'd0 - b) : b;

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // keeping the carry so the shift-right loses nothing.
    assign w_sum      = {1'b0, r_prod[63:32]} + {1'b0, (r_prod[0] ? r_opnd : 32'd0)};
    assign w_prod_fix = r_neg ? (64'd0 - r_prod) : r_prod;

`ifdef MDU_DIV_EN
    logic        r_is_div;
    logic [32:0] r_rem;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_accept  = start;
    // Restoring step: bring in the next dividend bit and try to subtract.
    // The partial remainder is always below the divisor, so bit 32 of the
    // difference is a clean borrow flag.
    assign w_shift   = {r_rem[31:0], r_prod[31]};
    assign w_diff    = w_shift - {1'b0, r_opnd};
    // Divide by zero yields all-ones quotient; the remainder path naturally
    // reconstructs a (magnitude with a's sign), so only LO needs forcing.
    assign w_quo_fix = (r_opnd == 32'd0) ? 32'hFFFF_FFFF
                     : (r_neg ? (32'd0 - r_prod[31:0]) : r_prod[31:0]);
    assign w_rem_fix = r_sa ? (32'd0 - r_rem[31:0]) : r_rem[31:0];
`else
    // Without the divide datapath, divide requests never leave idle.
    assign w_accept  = start & ~op[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_prod   <= 64'd0;
            r_opnd   <= 32'd0;
            r_sa     <= 1'b0;
            r_neg    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
`ifdef MDU_DIV_EN
            r_is_div <= 1'b0;
            r_rem    <= 33'd0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_hi) hi <= wr_data;
                    if (wr_lo) lo <= wr_data;
                    if (w_accept) begin
                        r_state  <= S_RUN;
                        busy     <= 1'b1;
                        r_cnt    <= 6'd0;
                        // Multiplication commutes, so both ops load |a| into
                        // the shifting half and |b| as the fixed operand.
                        r_prod   <= {32'd0, w_abs_a};
                        r_opnd   <= w_abs_b;
                        r_sa     <= w_signed & a[31];
                        r_neg    <= w_signed & (a[31] ^ b[31]);
`ifdef MDU_DIV_EN
                        r_is_div <= op[1];
                        r_rem    <= 33'd0;
`endif
                    end
                end

                S_RUN: begin
                    r_cnt <= r_cnt + 6'd1;
`ifdef MDU_DIV_EN
                    if (r_is_div) begin
                        if (!w_diff[32]) begin
                            r_rem         <= w_diff;
                            r_prod[31:0]  <= {r_prod[30:0], 1'b1};
                        end else begin
                            r_rem         <= w_shift;
                            r_prod[31:0]  <= {r_prod[30:0], 1'b0};
                        end
                    end else begin
                        r_prod <= {w_sum, r_prod[31:1]};
                    end
`else
                    r_prod <= {w_sum, r_prod[31:1]};
`endif
                    if (r_cnt == 6'd31) r_state <= S_FIX;
                end

                S_FIX: begin
`ifdef MDU_DIV_EN
                    if (r_is_div) begin
                        hi <= w_rem_fix;
                        lo <= w_quo_fix;
                    end else begin
                        hi <= w_prod_fix[63:32];
                        lo <= w_prod_fix[31:0];
                    end
`else
                    hi <= w_prod_fix[63:32];
                    lo <= w_prod_fix[31:0];
`endif
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit for the MIPS32 execute stage, alongside the combinational ALU. It takes the same rs/rt operands the ALU sees and computes MULT, MULTU, DIV and DIVU over multiple cycles into the architectural HI/LO registers. The core stalls on `busy`, and the writeback mux reads `hi`/`lo` for MFHI/MFLO next to the ALU `result`. MTHI/MTLO write HI/LO directly through a single write port.

## Interface
Parameters: none; width is fixed at 32.

Reset is synchronous and active-high; the block runs on one clock.

- `clk`  input  1  clock; all state updates on the rising edge
- `reset`  input  1  synchronous, active-high reset
- `start`  input  1  launch the operation in `op` on operands `a` and `b`; sampled only in IDLE
- `op`  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `a`  input  32  rs operand (multiplicand or dividend); sampled with `start`
- `b`  input  32  rt operand (multiplier or divisor); sampled with `start`
- `wr_hi`  input  1  MTHI: write `wr_data` into HI
- `wr_lo`  input  1  MTLO: write `wr_data` into LO
- `wr_data`  input  32  data for MTHI/MTLO
- `busy`  output  1  operation in progress; the core must stall on it
- `done`  output  1  one-cycle pulse when HI/LO are updated by an operation
- `hi`  output  32  HI register (product[63:32] or remainder)
- `lo`  output  32  LO register (product[31:0] or quotient)

## Operation
- **States:** IDLE, RUN, FIX.
- **IDLE:**
  - `start`=1 latches `op`, |a|, |b| and the operand signs, clears the 6-bit counter, and moves to RUN.
  - Magnitudes are taken only for signed ops (MULT, DIV); unsigned ops use the operands as-is.
- **RUN:** one iteration per cycle, 32 cycles, then FIX.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder.
- **FIX:** applies sign correction, writes HI/LO, pulses `done`, and returns to IDLE.
  - MULT: the product is negated if sign(a)≠sign(b).
  - DIV: the quotient is negated if sign(a)≠sign(b); the remainder takes the sign of a.
  - Unsigned ops skip correction.
- **Arithmetic rules:**
  - Internal accumulators are 64 bits (multiply) and 33 bits (divide partial remainder).
  - Magnitude of 0x8000_0000 is 0x8000_0000 treated as unsigned.
- **Divide by zero (DIV and DIVU):** hi=a, lo=32'hFFFF_FFFF, with normal latency and a `done` pulse.
- **DIV 0x8000_0000 / 0xFFFF_FFFF:** lo=32'h8000_0000, hi=0 (wraps; no trap).
- **`start` while busy:** ignored.
- **`wr_hi`/`wr_lo`:**
  - Applied on the edge only while IDLE; ignored during RUN and FIX.
  - If `start` and `wr_hi`/`wr_lo` arrive on the same IDLE edge, the write is applied, and FIX later overwrites both registers.
- **HI/LO during RUN:** they hold their previous values and are stale until `done`.

## Timing
- **Reset values:** `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE.
- **Reset mid-operation:** aborts the operation, applies all reset values, and produces no `done`.
- **Latency** (`start` accepted on edge E0):
  - `busy` is high from E0 through E33 and falls at E33.
  - RUN covers edges E1..E32.
  - FIX is edge E33: `hi`/`lo` are updated and `done`=1 for the cycle after E33.
- **Back-to-back operations:** the next `start` is accepted at the earliest on E34; there is no overlap.
- **Signal timing:** `done` and `busy` are registered outputs. `hi`/`lo` are registers, with no combinational path from inputs.
- **MTHI/MTLO:** the write is visible on `hi`/`lo` the cycle after the write edge.

## Configuration
- **`MDU_DIV_EN`:**
  - **Defined:** the full unit as specified.
  - **Undefined:**
    - The divide datapath is compiled out.
    - `start` with op[1]=1 is ignored: the unit stays IDLE, `busy` stays 0, HI/LO are unchanged and there is no `done`.
    - Multiply behaviour and timing are identical to the full unit.

## Test plan
- MULT a=0xFFFF_FFFD (−3), b=7 -> E33: hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; `done` for one cycle; `busy` high for exactly 33 cycles after E0.
- MULTU a=b=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001.
- Division results:
  - DIV a=0xFFFF_FFF9 (−7), b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
  - DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=5, b=0 -> hi=5, lo=0xFFFF_FFFF at normal latency.
- Write-port rules:
  - MTHI 0x1234_5678 in IDLE -> hi=0x1234_5678 the next cycle.
  - MTLO and `start` pulsed during RUN -> both ignored; the result is unchanged.
- `reset` at cycle 10 of a MULT -> next cycle: `busy`=0, hi=lo=0, no `done` pulse. A fresh MULT 6×7 afterwards gives lo=42, hi=0.
